// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 receive path.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] KC_IDLE  = 8'h00;
  localparam logic [7:0] KC_BREAK = 8'hF0;
  localparam logic [7:0] KC_EXT   = 8'hE0;
endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the raw PS/2 clock, debounces it over FILTER_LEN samples and
// emits a registered one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic fall_o
);
  logic [1:0]            sync_q, sync_d;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic                  fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[0], raw_i};
    hist_d = {hist_q[FILTER_LEN-2:0], sync_q[1]};
    filt_d = filt_q;
    // Only a full run of equal samples moves the output; anything shorter holds it.
    if (&hist_q)       filt_d = 1'b1;
    else if (~|hist_q) filt_d = 1'b0;
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      hist_q <= '1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
    end
  end

  assign fall_o = fall_q;
endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity,
// stop. Good bytes appear on keycode for exactly one cycle; errors are strobed.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       kc_valid,
  output logic [7:0] kc_last,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int            TW      = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

  logic          fall;
  logic [1:0]    dsync_q, dsync_d;
  logic          din;
  ps2_state_e    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    keycode_q, keycode_d;
  logic [7:0]    kc_last_q, kc_last_d;
  logic          kc_valid_q, kc_valid_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (ps2_clk),
    .fall_o (fall)
  );

  assign dsync_d = {dsync_q[0], ps2_data};
  assign din     = dsync_q[1];

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tmo_d        = tmo_q;
    keycode_d    = KC_IDLE;
    kc_last_d    = kc_last_q;
    kc_valid_d   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q == IDLE || fall) tmo_d = '0;
    else if (tmo_q != TMO_MAX)   tmo_d = tmo_q + TW'(1);

    case (state_q)
      IDLE: if (fall && !din) begin
        state_d  = DATA;
        bitcnt_d = 3'd0;
      end
      DATA: if (fall) begin
        shift_d  = {din, shift_q[7:1]};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        par_d   = din;
        state_d = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        // A bad stop bit outranks a parity error.
        if (!din) frame_err_d = 1'b1;
        else if (^{shift_q, par_q}) begin
          kc_valid_d = 1'b1;
          keycode_d  = shift_q;
          kc_last_d  = shift_q;
        end else parity_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A fall in the same cycle keeps the frame alive.
    if (state_q != IDLE && !fall && tmo_q == TMO_MAX) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsync_q      <= 2'b11;
      state_q      <= IDLE;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      keycode_q    <= KC_IDLE;
      kc_last_q    <= KC_IDLE;
      kc_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      dsync_q      <= dsync_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      keycode_q    <= keycode_d;
      kc_last_q    <= kc_last_d;
      kc_valid_q   <= kc_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign keycode    = keycode_q;
  assign kc_last    = kc_last_q;
  assign kc_valid   = kc_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frames are driven bit by bit, expected strobes
// are queued before each frame and matched as the receiver reports them.
module tb_ps2_rx;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode, kc_last;
  logic       kc_valid, parity_err, frame_err, busy;

  int          total = 0;
  int          bad = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  exp_last = 8'h00;
  logic        prev_strb = 1'b0;

  ps2_rx #(.FILTER_LEN(4), .TIMEOUT_CYC(200)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keycode    (keycode),
    .kc_valid   (kc_valid),
    .kc_last    (kc_last),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected events: {kc_valid, parity_err, frame_err, keycode}
  task automatic exp_ok(input logic [7:0] b);  exp_q.push_back({3'b100, b});     endtask
  task automatic exp_par();                    exp_q.push_back({3'b010, 8'h00}); endtask
  task automatic exp_frm();                    exp_q.push_back({3'b001, 8'h00}); endtask

  // Drives the first nfall bits of a frame; glitch_at puts a 2-clk low pulse
  // in the high phase before that bit's real falling edge.
  task automatic send(input logic [7:0] b, input bit bad_par, input bit stop_v,
                      input int nfall, input int glitch_at);
    logic [10:0] fr;
    fr = {stop_v, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nfall; i++) begin
      ps2_data = fr[i];
      if (i == glitch_at) begin
        wait_clk(10); ps2_clk = 1'b0; wait_clk(2); ps2_clk = 1'b1; wait_clk(8);
      end else wait_clk(HALF / 2);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
      wait_clk(HALF / 2);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) wait_clk(1);
    chk(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_strb <= 1'b0;
    else begin
      if (prev_strb) begin
        chk("keycode_after", keycode, 8'h00);
        chk("strobe_len", {kc_valid, parity_err, frame_err}, 3'b000);
      end
      if (kc_valid | parity_err | frame_err) begin
        if (exp_q.size() == 0) chk("unexpected", {kc_valid, parity_err, frame_err, keycode}, 0);
        else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          chk("event", {kc_valid, parity_err, frame_err, keycode}, e);
          if (e[10]) exp_last = e[7:0];
          chk("kc_last", kc_last, exp_last);
        end
      end
      prev_strb <= kc_valid | parity_err | frame_err;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    wait_clk(5);
    chk("reset_outs", {keycode, kc_valid, kc_last, parity_err, frame_err, busy}, 0);
    rst_n = 1'b1;
    wait_clk(10);

    // single good frame
    exp_ok(8'h16); send(8'h16, 0, 1, 11, -1); drain("t1_drain");
    chk("t1_last", kc_last, 8'h16);

    // break prefix then make code, back-to-back
    exp_ok(8'hF0); exp_ok(8'h16);
    send(8'hF0, 0, 1, 11, -1); send(8'h16, 0, 1, 11, -1); drain("t2_drain");

    // bad parity
    exp_par(); send(8'h26, 1, 1, 11, -1); drain("t3_drain");
    chk("t3_last", kc_last, 8'h16);

    // bad stop bit, then recovery
    exp_frm(); send(8'h1E, 0, 0, 11, -1);
    exp_ok(8'h1E); send(8'h1E, 0, 1, 11, -1); drain("t4_drain");

    // truncated frame times out
    exp_frm(); send(8'h1E, 0, 1, 5, -1);
    wait_clk(130);
    chk("t5_busy_hold", busy, 1);
    wait_clk(25);
    chk("t5_busy_drop", busy, 0);
    drain("t5_tmo");
    exp_ok(8'h1E); send(8'h1E, 0, 1, 11, -1); drain("t5_drain");

    // glitches in idle and mid-data are ignored
    ps2_clk = 1'b0; wait_clk(2); ps2_clk = 1'b1; wait_clk(30);
    chk("t6_idle_busy", busy, 0);
    exp_ok(8'h16); send(8'h16, 0, 1, 11, 3); drain("t6_glitch");

    // reset during D3
    send(8'h16, 0, 1, 4, -1);
    chk("t6_busy_mid", busy, 1);
    ps2_data = 1'b0; wait_clk(20); ps2_clk = 1'b0; wait_clk(3);
    rst_n = 1'b0; wait_clk(1);
    chk("t6_rst_busy", busy, 0);
    ps2_clk = 1'b1; wait_clk(10);
    exp_last = 8'h00;
    rst_n = 1'b1; wait_clk(20);
    chk("t6_rst_outs", {keycode, kc_valid, kc_last, parity_err, frame_err, busy}, 0);
    exp_ok(8'h16); send(8'h16, 0, 1, 11, -1); drain("t6_after_rst");

    wait_clk(50);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
